// File: rtl/rv_pkg.sv
// Shared RISC-V front-end types: data widths, the default reset PC and the
// fetch buffer entry that pairs an instruction word with its address.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are word-granular, so the low two address bits are cleared.
  function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// The master modport is the fetch unit's view; the slave modport is the environment's view.
interface instr_fetch_unit_if;
  import rv_pkg::*;

  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_imem_req_vld;
  logic [XLEN-1:0] o_imem_req_addr;
  logic            i_imem_req_rdy;
  logic            i_imem_rsp_vld;
  logic [ILEN-1:0] i_imem_rsp_data;
  logic            o_instr_vld;
  logic [ILEN-1:0] o_instr;
  logic [XLEN-1:0] o_pc;
  logic            i_instr_rdy;

  modport master (
    input  i_redirect, i_redirect_pc, i_imem_req_rdy, i_imem_rsp_vld,
           i_imem_rsp_data, i_instr_rdy,
    output o_imem_req_vld, o_imem_req_addr, o_instr_vld, o_instr, o_pc
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_imem_req_rdy, i_imem_rsp_vld,
           i_imem_rsp_data, i_instr_rdy,
    input  o_imem_req_vld, o_imem_req_addr, o_instr_vld, o_instr, o_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch entries with push, pop and flush.
// The head entry is read straight out of the storage registers.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CntW = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  fetch_entry_t    data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic            full_o,
  output logic            empty_o,
  output fetch_entry_t    head_o,
  output logic [CntW-1:0] count_o
);

  localparam int PtrW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign doPop   = pop_i && !empty_o;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign doPush  = push_i && (!full_o || doPop);
  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PtrW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PtrW'(1);
      count_d = count_q + CntW'(doPush) - CntW'(doPop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (doPush && !flush_i) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word fetches, buffers in-order responses
// for decode, and discards responses that were already in flight when a redirect hit.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input logic                i_clk,
  input logic                i_rst,
  instr_fetch_unit_if.master bus
);

  localparam int CntW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetchPc_q, fetchPc_d, rspPc_q, rspPc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d, drop_q, drop_d;
  logic [CntW-1:0] occupancy;
  logic            reqVld, reqHs, rspPush, popHs, fifoFull, fifoEmpty;
  fetch_entry_t    pushEntry, headEntry;

  // Every outstanding request has a reserved buffer slot, so responses never need backpressure.
  assign reqVld = !i_rst && !bus.i_redirect && !fifoFull &&
                  (({1'b0, occupancy} + {1'b0, outstanding_q}) < (CntW+1)'(FIFO_DEPTH));
  assign reqHs     = reqVld && bus.i_imem_req_rdy;
  assign rspPush   = bus.i_imem_rsp_vld && !bus.i_redirect && (drop_q == '0);
  assign popHs     = !fifoEmpty && bus.i_instr_rdy;
  assign pushEntry = '{pc: rspPc_q, instr: bus.i_imem_rsp_data};

  assign bus.o_imem_req_vld  = reqVld;
  assign bus.o_imem_req_addr = fetchPc_q;
  assign bus.o_instr_vld     = !fifoEmpty;
  assign bus.o_instr         = headEntry.instr;
  assign bus.o_pc            = headEntry.pc;

  always_comb begin
    fetchPc_d     = fetchPc_q;
    rspPc_d       = rspPc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CntW'(reqHs) - CntW'(bus.i_imem_rsp_vld);
    if (bus.i_redirect) begin
      fetchPc_d = alignWord(bus.i_redirect_pc);
      rspPc_d   = alignWord(bus.i_redirect_pc);
      drop_d    = outstanding_q - CntW'(bus.i_imem_rsp_vld);
    end else begin
      if (reqHs)   fetchPc_d = fetchPc_q + XLEN'(4);
      if (rspPush) rspPc_d   = rspPc_q + XLEN'(4);
      if (bus.i_imem_rsp_vld && (drop_q != '0)) drop_d = drop_q - CntW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetchPc_q     <= RESET_PC;
      rspPc_q       <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      rspPc_q       <= rspPc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .push_i (rspPush),
    .data_i (pushEntry),
    .pop_i  (popHs),
    .flush_i(bus.i_redirect),
    .full_o (fifoFull),
    .empty_o(fifoEmpty),
    .head_o (headEntry),
    .count_o(occupancy)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle-latency memory whose
// instruction word for address A is {16'hC0DE, A[15:0]}.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic memHold = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   reqCount = 0;
  logic [31:0] pending [$];

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory: requests seen before an edge are answered in the following cycle unless held.
  always begin : memModel
    logic        snapHs, snapHold, snapRst;
    logic [31:0] snapAddr, addr;
    @(negedge clk);
    snapHs   = bus.o_imem_req_vld & bus.i_imem_req_rdy;
    snapAddr = bus.o_imem_req_addr;
    snapHold = memHold;
    snapRst  = rst;
    @(posedge clk);
    #1;
    if (snapRst) begin
      pending.delete();
      reqCount = 0;
      bus.i_imem_rsp_vld  = 1'b0;
      bus.i_imem_rsp_data = '0;
    end else begin
      if (snapHs) begin
        pending.push_back(snapAddr);
        reqCount++;
      end
      if (!snapHold && pending.size() > 0) begin
        addr = pending.pop_front();
        bus.i_imem_rsp_vld  = 1'b1;
        bus.i_imem_rsp_data = {16'hC0DE, addr[15:0]};
      end else begin
        bus.i_imem_rsp_vld  = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic redir, input logic [31:0] redirPc,
                               input logic decRdy, input logic hold);
    @(posedge clk);
    #1;
    rst               = r;
    bus.i_redirect    = redir;
    bus.i_redirect_pc = redirPc;
    bus.i_instr_rdy   = decRdy;
    memHold           = hold;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic checkFetch(input string tag, input logic expVld, input logic [31:0] expAddr);
    checkOutput({tag, ".reqVld"}, 32'(bus.o_imem_req_vld), 32'(expVld));
    checkOutput({tag, ".reqAddr"}, bus.o_imem_req_addr, expAddr);
  endtask

  task automatic checkInstr(input string tag, input logic expVld, input logic [31:0] expPc);
    checkOutput({tag, ".instrVld"}, 32'(bus.o_instr_vld), 32'(expVld));
    if (expVld) begin
      checkOutput({tag, ".pc"}, bus.o_pc, expPc);
      checkOutput({tag, ".instr"}, bus.o_instr, {16'hC0DE, expPc[15:0]});
    end
  endtask

  task automatic checkReset(input string tag);
    checkFetch(tag, 1'b0, 32'h0);
    checkOutput({tag, ".instrVld"}, 32'(bus.o_instr_vld), 32'h0);
    checkOutput({tag, ".instr"}, bus.o_instr, 32'h0);
    checkOutput({tag, ".pc"}, bus.o_pc, 32'h0);
  endtask

  initial begin
    bus.i_redirect     = 1'b0;
    bus.i_redirect_pc  = '0;
    bus.i_imem_req_rdy = 1'b1;
    bus.i_instr_rdy    = 1'b1;
    #1 rst = 1'b1;
    #1;
    checkReset("rst0");

    // Streaming after reset release
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("a1", 1, 32'h0);   checkInstr("a1", 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("a2", 1, 32'h4);   checkInstr("a2", 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("a3", 0, 32'h8);   checkInstr("a3", 1, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("a4", 1, 32'h8);   checkInstr("a4", 1, 32'h4);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("a5", 1, 32'hC);   checkInstr("a5", 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("a6", 0, 32'h10);  checkInstr("a6", 1, 32'h8);

    // Decode stalled: buffer fills, requests stop, head holds
    applyStimulus(1, 0, 32'h0, 0, 0);
    checkReset("b_rst");
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkFetch("b1", 1, 32'h0);
    repeat (2) applyStimulus(0, 0, 32'h0, 0, 0);
    checkFetch("b3", 0, 32'h8);   checkInstr("b3", 1, 32'h0);
    repeat (7) applyStimulus(0, 0, 32'h0, 0, 0);
    checkFetch("b10", 0, 32'h8);  checkInstr("b10", 1, 32'h0);
    checkOutput("b10.reqCount", 32'(reqCount), 32'd2);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkInstr("b11", 1, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("b12", 1, 32'h8);  checkInstr("b12", 1, 32'h4);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("b13", 1, 32'hC);  checkInstr("b13", 0, 32'h0);

    // Reset with one outstanding and one buffered
    applyStimulus(1, 0, 32'h0, 1, 0);
    checkReset("c_rst");

    // Redirect with two responses in flight
    applyStimulus(0, 0, 32'h0, 1, 1);
    checkFetch("c_restart", 1, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1);
    checkFetch("d2", 1, 32'h4);
    applyStimulus(0, 1, 32'h100, 1, 0);
    checkFetch("d3", 0, 32'h8);   checkInstr("d3", 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("d4", 0, 32'h100); checkInstr("d4", 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("d5", 1, 32'h100); checkInstr("d5", 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("d6", 1, 32'h104); checkInstr("d6", 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("d7", 0, 32'h108); checkInstr("d7", 1, 32'h100);

    // Misaligned redirect target
    applyStimulus(0, 1, 32'h203, 1, 0);
    checkFetch("e8", 0, 32'h108); checkInstr("e8", 1, 32'h104);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("e9", 1, 32'h200); checkInstr("e9", 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("e10", 1, 32'h204);

    // Redirect together with a response and an output handshake
    applyStimulus(0, 1, 32'h300, 1, 0);
    checkFetch("f11", 0, 32'h208); checkInstr("f11", 1, 32'h200);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("f12", 1, 32'h300); checkInstr("f12", 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("f13", 1, 32'h304); checkInstr("f13", 0, 32'h0);

    // Fetch address wrap at the top of the address space
    applyStimulus(0, 1, 32'hFFFF_FFFC, 1, 0);
    checkFetch("g14", 0, 32'h308); checkInstr("g14", 1, 32'h300);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("g15", 1, 32'hFFFF_FFFC); checkInstr("g15", 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("g16", 1, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("g17", 0, 32'h4);  checkInstr("g17", 1, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("g18", 1, 32'h4);  checkInstr("g18", 1, 32'h0);

    // Back-to-back redirects: the later target wins
    applyStimulus(0, 1, 32'h400, 1, 0);
    checkFetch("h19", 0, 32'h8);  checkInstr("h19", 0, 32'h0);
    applyStimulus(0, 1, 32'h500, 1, 0);
    checkFetch("h20", 0, 32'h400);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("h21", 1, 32'h500); checkInstr("h21", 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkFetch("h22", 1, 32'h504);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkInstr("h23", 1, 32'h500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
